// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg
//   Shared definitions for the SRAM request arbiter: response-owner
//   encodings and the default starvation limit for instruction fetch.
package sram_arb_pkg;

  // Owner of the response that returns one cycle after a grant.
  typedef enum logic [1:0] {
    RESP_NONE = 2'b00,
    RESP_INST = 2'b01,
    RESP_DATA = 2'b10
  } resp_sel_e;

  // Consecutive denied fetch cycles before fetch is forced to win.
  localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter
//   Arbitrates the core's instruction-fetch and load/store requests onto one
//   synchronous-read SRAM (1-cycle read latency). Data wins by default; a
//   saturating counter forces one fetch grant after STARVE_MAX denied cycles.
//   cancel blocks a fetch grant in its cycle and drops any in-flight fetch
//   response.
//
// Ports
//   clk, resetn          clock, synchronous active-low reset
//   cancel               pipeline flush from WB
//   inst_*               fetch request / accept / response
//   data_*               load/store request / accept / response
//   mem_*                SRAM port (mem_rdata valid the cycle after mem_en)
module sram_req_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cancel,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  resp_sel_e  resp_sel_q, resp_sel_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       kill_q, kill_d;

  logic force_raw;   // starvation limit reached, ignoring cancel
  logic force_inst;
  logic gnt_inst;
  logic gnt_data;
  logic inst_would;  // fetch would have been granted had cancel been low

  // Grant logic. Every grant is gated by resetn so the SRAM and the masters
  // see nothing while reset is held.
  always_comb begin
    force_raw  = inst_req & (starve_cnt_q == STARVE_LIM);
    force_inst = resetn & force_raw & ~cancel;
    gnt_data   = resetn & data_req & ~force_inst;
    gnt_inst   = resetn & inst_req & ~cancel & (~data_req | force_inst);
    inst_would = inst_req & (~data_req | force_raw);
  end

  // SRAM port driven from whichever master won; idle bus reads as zero.
  always_comb begin
    mem_en    = gnt_inst | gnt_data;
    mem_wen   = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_data) begin
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
      mem_wen   = data_wr ? data_wstrb : 4'b0000;
    end else if (gnt_inst) begin
      mem_addr  = inst_addr;
    end
  end

  assign inst_addr_ok = gnt_inst;
  assign data_addr_ok = gnt_data;

  // A fetch response is suppressed both in the cancel cycle and in the cycle
  // after it, so a flushed fetch can never surface late.
  assign inst_data_ok = resetn & (resp_sel_q == RESP_INST) & ~cancel & ~kill_q;
  assign data_data_ok = resetn & (resp_sel_q == RESP_DATA);
  assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
  assign data_rdata   = data_data_ok ? mem_rdata : '0;

  // Next-state logic for the response owner, starvation counter and kill flag.
  always_comb begin
    resp_sel_d = RESP_NONE;
    if (gnt_inst) begin
      resp_sel_d = RESP_INST;
    end else if (gnt_data) begin
      resp_sel_d = RESP_DATA;
    end

    starve_cnt_d = starve_cnt_q;
    if (gnt_inst | ~inst_req | cancel) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q != STARVE_LIM) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    kill_d = cancel & (inst_would | (resp_sel_q == RESP_INST));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      resp_sel_q   <= RESP_NONE;
      starve_cnt_q <= 4'd0;
      kill_q       <= 1'b0;
    end else begin
      resp_sel_q   <= resp_sel_d;
      starve_cnt_q <= starve_cnt_d;
      kill_q       <= kill_d;
    end
  end

endmodule
